// File: rtl/rilib_io_ring_seq.sv
// rilib_io_ring_seq -- IO ring power-up / power-down sequencer.
// Watches the IO-supply level-detect flag and, once VDDIO has been stable
// for a debounce window, releases ring isolation and enables the IO banks
// one at a time. A software request walks the banks back down in reverse
// order. Loss of supply after isolation release forces the ring safe at once
// and latches a sticky error.
// Build option: define RIIO_RING_SEQ_FAST_SIM_EN to shorten the debounce and
// step intervals to 2 cycles for gate-level / top-level simulation.
module rilib_io_ring_seq #(
  parameter int NBANK    = 4,
  parameter int DEB_CYC  = 16,
  parameter int STEP_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vddio_ok_i,
  input  logic             sw_req_i,
  output logic             pad_iso_o,
  output logic [NBANK-1:0] pad_oe_en_o,
  output logic             ring_ready_o,
  output logic             seq_err_o
);

`ifdef RIIO_RING_SEQ_FAST_SIM_EN
  localparam int DebEff  = 2;
  localparam int StepEff = 2;
`else
  localparam int DebEff  = DEB_CYC;
  localparam int StepEff = STEP_CYC;
`endif

  localparam int CntMax = (DebEff > StepEff) ? DebEff : StepEff;
  localparam int CW     = $clog2(CntMax);
  localparam int IW     = $clog2(NBANK) + 1;

  localparam logic [CW-1:0] DebLast  = CW'(DebEff - 1);
  localparam logic [CW-1:0] StepLast = CW'(StepEff - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(NBANK - 1);
  localparam logic [IW-1:0] IdxZero  = '0;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_DEBOUNCE,
    ST_ISO_REL,
    ST_BANK_EN,
    ST_READY,
    ST_SHUTDOWN
  } state_e;

  logic [1:0]       sync_q;
  logic             sw_q;
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    idx_q;
  logic             iso_q;
  logic [NBANK-1:0] oe_q;
  logic             ready_q;
  logic             err_q;

  logic ok_s;
  logic supply_lost;
  logic deb_done;
  logic step_done;

  assign ok_s      = sync_q[1];
  assign deb_done  = (cnt_q == DebLast);
  assign step_done = (cnt_q == StepLast);

  // Supply loss only matters once isolation has been (or is being) released.
  assign supply_lost = !ok_s && (state_q inside {ST_ISO_REL, ST_BANK_EN, ST_READY, ST_SHUTDOWN});

  // Two-flop synchronizer for the asynchronous level-detect flag, plus a
  // registered copy of the software request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      sw_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], vddio_ok_i};
      sw_q   <= sw_req_i;
    end
  end

  // Sequencer: state, step counters and all ring controls, updated together.
  // Bank enables stay thermometer-coded, so stepping up is a shift-in of a 1
  // and stepping down is a right shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      iso_q   <= 1'b1;
      oe_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (supply_lost) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      iso_q   <= 1'b1;
      oe_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (ok_s && !sw_q) begin
            state_q <= ST_DEBOUNCE;
            cnt_q   <= '0;
          end
        end
        ST_DEBOUNCE: begin
          if (!ok_s) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
          end else if (deb_done) begin
            state_q <= ST_ISO_REL;
            cnt_q   <= '0;
            iso_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_ISO_REL: begin
          if (step_done) begin
            state_q <= ST_BANK_EN;
            cnt_q   <= '0;
            idx_q   <= '0;
            oe_q    <= NBANK'(1);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_BANK_EN: begin
          if (step_done) begin
            cnt_q <= '0;
            if (idx_q == IdxLast) begin
              state_q <= ST_READY;
              ready_q <= 1'b1;
            end else begin
              oe_q  <= (oe_q << 1) | NBANK'(1);
              idx_q <= idx_q + IW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_READY: begin
          if (sw_q) begin
            state_q <= ST_SHUTDOWN;
            cnt_q   <= '0;
            idx_q   <= IdxLast;
            ready_q <= 1'b0;
            oe_q    <= oe_q >> 1;
          end
        end
        ST_SHUTDOWN: begin
          if (step_done) begin
            cnt_q <= '0;
            if (idx_q == IdxZero) begin
              state_q <= ST_OFF;
              iso_q   <= 1'b1;
            end else begin
              oe_q  <= oe_q >> 1;
              idx_q <= idx_q - IW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_OFF;
          cnt_q   <= '0;
          idx_q   <= '0;
          iso_q   <= 1'b1;
          oe_q    <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign pad_iso_o    = iso_q;
  assign pad_oe_en_o  = oe_q;
  assign ring_ready_o = ready_q;
  assign seq_err_o    = err_q;

endmodule

// File: tb/tb_rilib_io_ring_seq.sv
// Bench for rilib_io_ring_seq: directed scenarios followed by random supply /
// request activity, all checked every cycle against a timeline model that
// derives the outputs from elapsed time since power-up or shutdown began.
module tb_rilib_io_ring_seq;

  localparam int NB   = 4;
  localparam int DEB  = 16;
  localparam int STEP = 8;

  localparam int P_OFF   = 0;
  localparam int P_UP    = 1;
  localparam int P_READY = 2;
  localparam int P_DOWN  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vddio;
  logic          sw;
  logic          iso;
  logic [NB-1:0] oe;
  logic          rdy;
  logic          err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int edge_n = 0;

  // model state
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_sw = 1'b0, m_err = 1'b0;
  int   m_ph = P_OFF;
  int   m_e  = 0;
  int   m_s  = 0;

  rilib_io_ring_seq #(.NBANK(NB), .DEB_CYC(DEB), .STEP_CYC(STEP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vddio_ok_i  (vddio),
    .sw_req_i    (sw),
    .pad_iso_o   (iso),
    .pad_oe_en_o (oe),
    .ring_ready_o(rdy),
    .seq_err_o   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Advance the timeline model by one clock edge using the inputs seen there.
  task automatic model_edge();
    logic ok, swv;
    ok  = m_s2;
    swv = m_sw;
    if (!rst_n) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_sw = 1'b0; m_err = 1'b0;
      m_ph = P_OFF; m_e = 0; m_s = 0;
      return;
    end
    m_s2 = m_s1;
    m_s1 = vddio;
    m_sw = sw;
    case (m_ph)
      P_OFF: if (ok && !swv) begin m_ph = P_UP; m_e = 0; end
      P_UP: begin
        if (!ok) begin
          if (m_e >= DEB) m_err = 1'b1;
          m_ph = P_OFF;
        end else begin
          m_e++;
          if (m_e == DEB + STEP * (NB + 1)) m_ph = P_READY;
        end
      end
      P_READY: begin
        if (!ok) begin m_err = 1'b1; m_ph = P_OFF; end
        else if (swv) begin m_ph = P_DOWN; m_s = 1; end
      end
      default: begin
        if (!ok) begin m_err = 1'b1; m_ph = P_OFF; end
        else begin
          m_s++;
          if (m_s == 1 + STEP * NB) m_ph = P_OFF;
        end
      end
    endcase
  endtask

  // One clock: update model at the edge, compare all outputs mid-cycle.
  task automatic tick();
    int nb, mask;
    logic e_iso, e_rdy;
    logic [NB-1:0] e_oe;
    @(posedge clk);
    model_edge();
    edge_n++;
    @(negedge clk);
    case (m_ph)
      P_OFF:   begin e_iso = 1'b1; nb = 0;  e_rdy = 1'b0; end
      P_UP: begin
        e_iso = (m_e < DEB);
        nb    = (m_e < DEB) ? 0 : (m_e - DEB) / STEP;
        if (nb > NB) nb = NB;
        e_rdy = 1'b0;
      end
      P_READY: begin e_iso = 1'b0; nb = NB; e_rdy = 1'b1; end
      default: begin e_iso = 1'b0; nb = NB - 1 - (m_s - 1) / STEP; e_rdy = 1'b0; end
    endcase
    mask = (1 << nb) - 1;
    e_oe = mask[NB-1:0];
    chk("model_iso", 32'(iso), 32'(e_iso));
    chk("model_oe",  32'(oe),  32'(e_oe));
    chk("model_rdy", 32'(rdy), 32'(e_rdy));
    chk("model_err", 32'(err), 32'(m_err));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; vddio = 1'b0; sw = 1'b0;

    // Reset state
    ticks(4);
    chk("rst_iso", 32'(iso), 32'd1);
    chk("rst_oe",  32'(oe),  32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Power-up with defaults
    rst_n = 1'b1; vddio = 1'b1; edge_n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      case (edge_n)
        18: chk("pu_iso18", 32'(iso), 32'd1);
        19: chk("pu_iso19", 32'(iso), 32'd0);
        26: chk("pu_oe26",  32'(oe),  32'h0);
        27: chk("pu_oe27",  32'(oe),  32'h1);
        35: chk("pu_oe35",  32'(oe),  32'h3);
        43: chk("pu_oe43",  32'(oe),  32'h7);
        50: chk("pu_oe50",  32'(oe),  32'h7);
        51: chk("pu_oe51",  32'(oe),  32'hf);
        58: chk("pu_rdy58", 32'(rdy), 32'd0);
        59: begin chk("pu_rdy59", 32'(rdy), 32'd1); chk("pu_err59", 32'(err), 32'd0); end
        default: ;
      endcase
    end

    // Glitch during debounce, then full restart
    rst_n = 1'b0; vddio = 1'b0; tick(); rst_n = 1'b1;
    vddio = 1'b1; edge_n = 0;
    ticks(10);
    vddio = 1'b0;
    ticks(5);
    chk("gl_iso", 32'(iso), 32'd1);
    chk("gl_err", 32'(err), 32'd0);
    vddio = 1'b1; edge_n = 0;
    for (int i = 0; i < 59; i++) begin
      tick();
      case (edge_n)
        18: chk("gl_iso18", 32'(iso), 32'd1);
        19: chk("gl_iso19", 32'(iso), 32'd0);
        59: chk("gl_rdy59", 32'(rdy), 32'd1);
        default: ;
      endcase
    end

    // Shutdown from READY
    sw = 1'b1; tick(); edge_n = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      case (edge_n)
        1:  begin chk("sd_oe1", 32'(oe), 32'h7); chk("sd_rdy1", 32'(rdy), 32'd0); end
        8:  chk("sd_oe8",  32'(oe),  32'h7);
        9:  chk("sd_oe9",  32'(oe),  32'h3);
        17: chk("sd_oe17", 32'(oe),  32'h1);
        25: chk("sd_oe25", 32'(oe),  32'h0);
        32: chk("sd_iso32", 32'(iso), 32'd0);
        33: chk("sd_iso33", 32'(iso), 32'd1);
        45: chk("sd_iso45", 32'(iso), 32'd1);
        default: ;
      endcase
    end
    sw = 1'b0;

    // Supply loss in BANK_EN, error stays through re-power-up
    rst_n = 1'b0; vddio = 1'b0; tick(); rst_n = 1'b1;
    vddio = 1'b1; edge_n = 0;
    ticks(40);
    chk("sl_oe40", 32'(oe), 32'h3);
    vddio = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (edge_n == 42) begin
        chk("sl_oe42", 32'(oe), 32'h3);
        chk("sl_err42", 32'(err), 32'd0);
      end
      if (edge_n == 43) begin
        chk("sl_iso43", 32'(iso), 32'd1);
        chk("sl_oe43",  32'(oe),  32'h0);
        chk("sl_err43", 32'(err), 32'd1);
      end
    end
    vddio = 1'b1;
    ticks(70);
    chk("sl_rdy_again", 32'(rdy), 32'd1);
    chk("sl_err_kept",  32'(err), 32'd1);

    // Supply loss and shutdown request on the same cycle
    vddio = 1'b0; tick();
    sw = 1'b1; tick();
    chk("sim_rdy_hold", 32'(rdy), 32'd1);
    tick();
    chk("sim_iso", 32'(iso), 32'd1);
    chk("sim_oe",  32'(oe),  32'h0);
    chk("sim_rdy", 32'(rdy), 32'd0);
    chk("sim_err", 32'(err), 32'd1);
    sw = 1'b0;

    // Reset in the middle of shutdown
    vddio = 1'b1; ticks(70);
    sw = 1'b1; tick(); ticks(10);
    chk("rm_oe", 32'(oe), 32'h3);
    rst_n = 1'b0; tick();
    chk("rm_iso", 32'(iso), 32'd1);
    chk("rm_oe0", 32'(oe),  32'h0);
    chk("rm_rdy", 32'(rdy), 32'd0);
    chk("rm_err", 32'(err), 32'd0);
    rst_n = 1'b1; sw = 1'b0;

    // Random supply / request / reset activity
    for (int ep = 0; ep < 40; ep++) begin
      case ($urandom_range(0, 5))
        0: begin vddio = 1'b1; sw = 1'b0; ticks($urandom_range(5, 80)); end
        1: begin sw = 1'b1; ticks($urandom_range(1, 45)); end
        2: begin sw = 1'b0; ticks($urandom_range(1, 20)); end
        3: begin vddio = 1'b0; ticks($urandom_range(1, 6)); end
        4: begin vddio = 1'b1; sw = 1'($urandom_range(0, 1)); ticks($urandom_range(1, 30)); end
        default: begin rst_n = 1'b0; ticks($urandom_range(1, 3)); rst_n = 1'b1; end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
